// File: rtl/fifo_pkg.sv
// Shared definitions for the watermark FIFO: read-mode encodings and the
// occupancy-counter width helper.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the watermark FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int NUM_BITS = 32,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [NUM_BITS-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [NUM_BITS-1:0]        rdata
);

  logic [NUM_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_wm.sv
// Single-clock FIFO with almost-full/almost-empty watermarks, sticky
// overflow/underflow flags, flush, and selectable standard or FWFT read.
module fifo_wm
  import fifo_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int MODE     = FIFO_STD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd,
  input  logic                            wr,
  input  logic                            flush,
  input  logic                            clr_err,
  input  logic [NUM_BITS-1:0]             data_in,
  output logic [NUM_BITS-1:0]             data_out,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [count_width(DEPTH)-1:0]   fifo_counter,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [NUM_BITS-1:0] rd_data;
  logic                rd_acc;
  logic                wr_acc;
  logic                ovf_set;
  logic                unf_set;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);
  assign fifo_counter = count;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc  = rd & ~empty & ~flush;
  assign wr_acc  = wr & (~full | rd_acc) & ~flush;
  assign ovf_set = wr & ~wr_acc & ~flush;
  assign unf_set = rd & empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
    end
  end

  // Setting an error flag wins over clearing it in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .NUM_BITS(NUM_BITS),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        data_out <= '0;
        else if (flush)  data_out <= '0;
        else if (rd_acc) data_out <= rd_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_wm.sv
// Bench for fifo_wm: a standard-mode instance checked against a queue model and
// a vector table, plus an FWFT instance exercised with a short directed sequence.
module tb_fifo_wm;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  fifo_counter;

  logic        f_rd = 1'b0, f_wr = 1'b0, f_flush = 1'b0, f_clr = 1'b0;
  logic [31:0] f_din = '0;
  logic [31:0] f_dout;
  logic        f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [3:0]  f_count;

  logic [31:0] model_q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [31:0] m_dout = '0;
  int          check_count = 0;
  int          pass_count  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] din;
    int          exp_count;
    logic        exp_full;
    logic        exp_af;
    logic        exp_ovf;
    logic        exp_unf;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  fifo_wm #(.NUM_BITS(32), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .MODE(0)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .flush(flush), .clr_err(clr_err),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_counter(fifo_counter), .overflow(overflow), .underflow(underflow)
  );

  fifo_wm #(.NUM_BITS(32), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .MODE(1)) dut_fwft (
    .clk(clk), .rst(rst), .rd(f_rd), .wr(f_wr), .flush(f_flush), .clr_err(f_clr),
    .data_in(f_din), .data_out(f_dout), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af),
    .fifo_counter(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Drives one cycle on the standard instance and advances the queue model.
  task automatic applyStimulus(input logic r, input logic w, input logic fl,
                               input logic cl, input logic [31:0] d);
    logic m_empty, m_full, r_acc, w_acc;
    rd = r; wr = w; flush = fl; clr_err = cl; data_in = d;
    m_empty = (model_q.size() == 0);
    m_full  = (model_q.size() == DEPTH);
    r_acc   = r && !m_empty && !fl;
    w_acc   = w && (!m_full || r_acc) && !fl;
    if (!fl && w && !w_acc) m_ovf = 1'b1;
    else if (cl)            m_ovf = 1'b0;
    if (!fl && r && m_empty) m_unf = 1'b1;
    else if (cl)             m_unf = 1'b0;
    if (fl) begin
      model_q.delete();
      m_dout = '0;
    end else begin
      if (r_acc) m_dout = model_q.pop_front();
      if (w_acc) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n = model_q.size();
    check({tag, ".count"}, 32'(fifo_counter), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full), 32'(n == DEPTH));
    check({tag, ".ae"},    32'(almost_empty), 32'(n <= 2));
    check({tag, ".af"},    32'(almost_full), 32'(n >= 6));
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, ".unf"},   32'(underflow), 32'(m_unf));
    check({tag, ".dout"},  data_out, m_dout);
  endtask

  task automatic applyFwft(input logic r, input logic w, input logic fl, input logic [31:0] d);
    f_rd = r; f_wr = w; f_flush = fl; f_din = d;
    @(posedge clk);
    #1;
    f_rd = 1'b0; f_wr = 1'b0; f_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i] = '{rd: 1'b0, wr: 1'b1, din: 32'(i + 1),
                  exp_count: (i + 1 > 8) ? 8 : i + 1, exp_full: (i + 1 >= 8),
                  exp_af: (i + 1 >= 6), exp_ovf: (i == 8), exp_unf: 1'b0, exp_dout: '0};
    end
    for (int j = 1; j <= 9; j++) begin
      vecs[8 + j] = '{rd: 1'b1, wr: 1'b0, din: '0,
                      exp_count: (j <= 8) ? 8 - j : 0, exp_full: 1'b0,
                      exp_af: ((8 - j) >= 6), exp_ovf: 1'b1, exp_unf: (j == 9),
                      exp_dout: (j <= 8) ? 32'(j) : 32'd8};
    end

    // Reset values while rst is held low, before the first clock edge.
    #3;
    checkOutput("reset");
    check("reset.f_empty", 32'(f_empty), 32'd1);
    check("reset.f_dout", f_dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill past full, then drain past empty.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, 1'b0, 1'b0, vecs[i].din);
      checkOutput($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tcount", i), 32'(fifo_counter), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d.tfull", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d.taf", i), 32'(almost_full), 32'(vecs[i].exp_af));
      check($sformatf("vec%0d.tovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.tunf", i), 32'(underflow), 32'(vecs[i].exp_unf));
      check($sformatf("vec%0d.tdout", i), data_out, vecs[i].exp_dout);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("clr");
    check("clr.ovf0", 32'(overflow), 32'd0);
    check("clr.unf0", 32'(underflow), 32'd0);

    // Simultaneous read and write on a full FIFO.
    for (int v = 11; v <= 18; v++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(v));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd100);
    checkOutput("full_rw");
    check("full_rw.count8", 32'(fifo_counter), 32'd8);
    check("full_rw.dout11", data_out, 32'd11);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("full_rw_pop%0d", k));
    end
    check("full_rw.eighth", data_out, 32'd100);

    // Simultaneous read and write on an empty FIFO.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    checkOutput("empty_rw");
    check("empty_rw.count1", 32'(fifo_counter), 32'd1);
    check("empty_rw.unf", 32'(underflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("empty_rw_pop");
    check("empty_rw_pop.dout7", data_out, 32'd7);

    // Pointer wrap-around with interleaved push/pop pairs.
    for (int v = 1; v <= 20; v++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(v));
      check($sformatf("wrap%0d.count", v), 32'(fifo_counter), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("wrap%0d", v));
      check($sformatf("wrap%0d.dout", v), data_out, 32'(v));
    end

    // Flush leaves sticky flags alone and zeroes data_out.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int v = 31; v <= 33; v++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(v));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd99);
    checkOutput("flush");
    check("flush.unf_kept", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checkOutput("flush_clr");

    // Asynchronous reset mid-operation at count 5.
    for (int v = 51; v <= 55; v++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'(v));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd56);
    checkOutput("pre_rst");
    #2;
    rst = 1'b0;
    model_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    #1;
    checkOutput("async_rst");
    check("async_rst.dout0", data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd42);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("post_rst");
    check("post_rst.dout42", data_out, 32'd42);

    // First-word-fall-through instance.
    applyFwft(1'b0, 1'b1, 1'b0, 32'hA5);
    check("fwft.a5", f_dout, 32'hA5);
    check("fwft.count1", 32'(f_count), 32'd1);
    applyFwft(1'b0, 1'b1, 1'b0, 32'hB6);
    check("fwft.hold_a5", f_dout, 32'hA5);
    applyFwft(1'b1, 1'b0, 1'b0, '0);
    check("fwft.b6", f_dout, 32'hB6);
    check("fwft.count_rd", 32'(f_count), 32'd1);
    applyFwft(1'b0, 1'b1, 1'b0, 32'hC7);
    applyFwft(1'b0, 1'b1, 1'b0, 32'hD8);
    check("fwft.count3", 32'(f_count), 32'd3);
    check("fwft.head_b6", f_dout, 32'hB6);
    applyFwft(1'b0, 1'b0, 1'b1, '0);
    check("fwft.flush_empty", 32'(f_empty), 32'd1);
    check("fwft.flush_dout", f_dout, 32'd0);
    check("fwft.flush_count", 32'(f_count), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fifo_wm.md
FIFO_WM -- requirements
Module: fifo_wm

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty threshold.
REQ-005 SHALL have parameter MODE, default 0: 0 = standard read, 1 = first-word-fall-through (FWFT).
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port rd, input, 1: read request.
REQ-009 SHALL have port wr, input, 1: write request.
REQ-010 SHALL have port flush, input, 1: synchronous empty command.
REQ-011 SHALL have port clr_err, input, 1: synchronous clear of the sticky error flags.
REQ-012 SHALL have port data_in, input, NUM_BITS: write data.
REQ-013 SHALL have port data_out, output, NUM_BITS: read data.
REQ-014 SHALL have port empty, output, 1: count == 0.
REQ-015 SHALL have port full, output, 1: count == DEPTH.
REQ-016 SHALL have port almost_empty, output, 1: count <= AE_LEVEL.
REQ-017 SHALL have port almost_full, output, 1: count >= AF_LEVEL.
REQ-018 SHALL have port fifo_counter, output, $clog2(DEPTH)+1: current occupancy.
REQ-019 SHALL have port overflow, output, 1: sticky flag, write rejected.
REQ-020 SHALL have port underflow, output, 1: sticky flag, read rejected.

Function
REQ-021 SHALL accept a read (rd_acc) when rd=1 and empty=0.
REQ-022 SHALL accept a write (wr_acc) when wr=1 and either full=0 or rd_acc=1 in the same cycle.
REQ-023 SHALL, on wr_acc, store data_in at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-024 SHALL, on rd_acc, increment rd_ptr modulo DEPTH; pointers wrap with no gap or stall.
REQ-025 SHALL update fifo_counter as +1 for write only, -1 for read only, and unchanged for both or neither.
REQ-026 SHALL, with rd=wr=1 and the FIFO empty, accept the write, reject the read, set underflow, and give count 1.
REQ-027 SHALL, with rd=wr=1 and the FIFO full, accept both and keep count at DEPTH with FIFO order preserved.
REQ-028 SHALL, in MODE 0, register data_out with mem[rd_ptr] at the edge of rd_acc (1-cycle latency) and hold it otherwise.
REQ-029 SHALL, in MODE 1, drive data_out with mem[rd_ptr] whenever empty=0: the first write is visible the cycle after wr_acc, and rd_acc advances to the next entry; data_out is 0 while empty.
REQ-030 SHALL derive empty, full, almost_empty and almost_full combinationally from the registered count, with no added latency.
REQ-031 SHALL set overflow on wr=1 without wr_acc, and set underflow on rd=1 with empty=1; both hold until clr_err or reset.
REQ-032 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-033 SHALL, on flush=1, zero pointers and count next edge, ignore rd/wr in that cycle, and set data_out to 0 without changing the error flags.
REQ-034 SHALL leave stored entries outside the occupied range don't-care, never observable on data_out.

Reset
REQ-035 SHALL, while rst=0, immediately (asynchronously) force data_out=0, empty=1, full=0, almost_empty=1, almost_full=0 (if AF_LEVEL>0), fifo_counter=0, overflow=0, underflow=0, and pointers=0.
REQ-036 SHALL discard FIFO content on reset mid-operation; the first read after release returns the first post-reset write.
REQ-037 SHALL NOT reset the memory array.

Structure
REQ-038 SHALL place MODE encodings (FIFO_STD=0, FIFO_FWFT=1) and the count-width helper in shared package fifo_pkg.
REQ-039 SHALL implement storage in one sub-module fifo_mem (synchronous write, asynchronous read, NUM_BITS x DEPTH); pointer/count/flag logic stays in fifo_wm.

Verification
REQ-040 SHALL cover, with DEPTH=8 and AF_LEVEL=6: push 1..9 -> 9th rejected, full=1, count=8, overflow=1, almost_full asserted from count 6.
REQ-041 SHALL cover, from full: 9 pops -> data_out 1..8 in order, then empty=1 and underflow=1; clr_err -> both flags 0.
REQ-042 SHALL cover, when full: rd=wr=1 with 100 -> count stays 8, 100 read out eighth; when empty: rd=wr=1 with 7 -> count 1, underflow=1.
REQ-043 SHALL cover wrap-around: 20 interleaved push/pop pairs of values 1..20 -> outputs 1..20 in order, count never exceeds 1.
REQ-044 SHALL cover reset mid-operation: rst=0 asynchronously at count 5 -> all outputs take reset values before next edge; push 42 then pop -> 42.
REQ-045 SHALL cover MODE=1: push 0xA5 -> data_out=0xA5 next cycle with no rd; flush at count 3 -> empty=1, data_out=0.
